// File: rtl/noc_mmr_ctrl.sv
// noc_mmr_ctrl: memory-mapped NoC transmit controller.
// Software fills a 4-word packet bank (PKT[0] header, PKT[1..3] payload)
// through MMR writes, then writes the ctrl word to launch a transfer.
// The controller serialises the bank as FLITS flits using valid/ready.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   mmr_we               MMR write strobe
//   mmr_location         MMR write address
//   loadnoc_data         MMR write data
//   mmr_rd_addr          readback address
//   mmr_rd_data          combinational readback data
//   noc_valid/noc_data   flit presented to the link
//   noc_ready            link accepts the flit this cycle
//   noc_busy             transfer in progress
//   noc_done             one-cycle pulse after the last flit is accepted
//   noc_err              sticky flag: PKT/ctrl write attempted while busy
module noc_mmr_ctrl #(
    parameter int          FLITS    = 4,
    parameter logic [31:0] MMR_BASE = 32'h0000_4000,
    parameter logic [31:0] MMR_CTRL = 32'h0000_4010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mmr_we,
    input  logic [31:0] mmr_location,
    input  logic [31:0] loadnoc_data,
    input  logic [31:0] mmr_rd_addr,
    output logic [31:0] mmr_rd_data,
    output logic        noc_valid,
    output logic [31:0] noc_data,
    input  logic        noc_ready,
    output logic        noc_busy,
    output logic        noc_done,
    output logic        noc_err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] pkt [4];
    logic [31:0] pkt_n [4];
    logic        err_q, err_n;
    logic        done_q, done_n;
    logic        sticky_q, sticky_n;

    logic wr_pkt, wr_ctrl, last;

    // Address bits [1:0] are don't-care for word-wide registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{mmr_location[1:0], mmr_rd_addr[1:0]};

    assign wr_pkt  = mmr_we && (mmr_location[31:4] == MMR_BASE[31:4]);
    assign wr_ctrl = mmr_we && (mmr_location[31:2] == MMR_CTRL[31:2]);
    assign last    = (cnt == 2'(FLITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) pkt[i] <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            err_q    <= err_n;
            done_q   <= done_n;
            sticky_q <= sticky_n;
            for (int unsigned i = 0; i < 4; i++) pkt[i] <= pkt_n[i];
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pkt_n    = pkt;
        err_n    = err_q;
        done_n   = 1'b0;
        sticky_n = sticky_q;
        case (state)
            IDLE: begin
                if (wr_pkt) pkt_n[mmr_location[3:2]] = loadnoc_data;
                if (wr_ctrl) begin
                    if (loadnoc_data[1]) err_n = 1'b0;
                    if (loadnoc_data[0]) begin
                        state_n  = SEND;
                        cnt_n    = '0;
                        sticky_n = 1'b0;
                    end
                end
            end
            SEND: begin
                // Any bank/ctrl write while busy is dropped, including a
                // start on the final-acceptance edge.
                if (wr_pkt || wr_ctrl) err_n = 1'b1;
                if (noc_ready) begin
                    if (last) begin
                        state_n  = IDLE;
                        cnt_n    = '0;
                        done_n   = 1'b1;
                        sticky_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        noc_valid = (state == SEND);
        noc_busy  = (state == SEND);
        noc_data  = (state == SEND) ? pkt[cnt] : '0;
        noc_done  = done_q;
        noc_err   = err_q;
        if (mmr_rd_addr[31:4] == MMR_BASE[31:4])
            mmr_rd_data = pkt[mmr_rd_addr[3:2]];
        else if (mmr_rd_addr[31:2] == MMR_CTRL[31:2])
            mmr_rd_data = {29'b0, err_q, sticky_q, noc_busy};
        else
            mmr_rd_data = '0;
    end

endmodule

// File: tb/tb_noc_mmr_ctrl.sv
module tb_noc_mmr_ctrl;
    logic        clk = 1'b0;
    logic        reset, mmr_we, noc_ready;
    logic [31:0] mmr_location, loadnoc_data, mmr_rd_addr;
    logic [31:0] mmr_rd_data, noc_data;
    logic        noc_valid, noc_busy, noc_done, noc_err;

    noc_mmr_ctrl #(.FLITS(4), .MMR_BASE(32'h0000_4000), .MMR_CTRL(32'h0000_4010)) dut (
        .clk(clk), .reset(reset), .mmr_we(mmr_we), .mmr_location(mmr_location),
        .loadnoc_data(loadnoc_data), .mmr_rd_addr(mmr_rd_addr), .mmr_rd_data(mmr_rd_data),
        .noc_valid(noc_valid), .noc_data(noc_data), .noc_ready(noc_ready),
        .noc_busy(noc_busy), .noc_done(noc_done), .noc_err(noc_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: a transfer is a queue of pending flits.
    logic [31:0] m_pkt [4];
    logic [31:0] m_q [$];
    logic        m_err, m_sticky, m_done;
    int          accepts;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a >= 32'h4000 && a <= 32'h400F) return m_pkt[a[3:2]];
        if (a >= 32'h4010 && a <= 32'h4013)
            return {29'b0, m_err, m_sticky, (m_q.size() != 0)};
        return 32'h0;
    endfunction

    // One clock: drive inputs, check current outputs, advance the model.
    task automatic cyc(input logic we_i, input logic [31:0] loc, input logic [31:0] dat,
                       input logic rdy, input logic rst, input logic [31:0] rda);
        logic busy_m, hit_pkt, hit_ctrl;
        @(negedge clk);
        mmr_we = we_i; mmr_location = loc; loadnoc_data = dat;
        noc_ready = rdy; reset = rst; mmr_rd_addr = rda;
        #1;
        busy_m = (m_q.size() != 0);
        check("valid", {31'b0, noc_valid}, {31'b0, busy_m});
        check("busy",  {31'b0, noc_busy},  {31'b0, busy_m});
        check("data",  noc_data, busy_m ? m_q[0] : 32'h0);
        check("done",  {31'b0, noc_done},  {31'b0, m_done});
        check("err",   {31'b0, noc_err},   {31'b0, m_err});
        check("rdata", mmr_rd_data, m_read(rda));
        hit_pkt  = we_i && loc >= 32'h4000 && loc <= 32'h400F;
        hit_ctrl = we_i && loc >= 32'h4010 && loc <= 32'h4013;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_pkt[i] = 32'h0;
            m_q.delete(); m_err = 0; m_sticky = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (busy_m) begin
                if (hit_pkt || hit_ctrl) m_err = 1;
                if (rdy) begin
                    void'(m_q.pop_front());
                    accepts++;
                    if (m_q.size() == 0) begin m_done = 1; m_sticky = 1; end
                end
            end else begin
                if (hit_pkt) m_pkt[loc[3:2]] = dat;
                if (hit_ctrl) begin
                    if (dat[1]) m_err = 0;
                    if (dat[0]) begin
                        for (int i = 0; i < 4; i++) m_q.push_back(m_pkt[i]);
                        m_sticky = 0;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(0, 32'h0, 32'h0, rdy, 0, 32'h4010);
    endtask

    task automatic load_pkt;
        cyc(1, 32'h4000, 32'h11,        1, 0, 32'h4000);
        cyc(1, 32'h4004, 32'hA0A0A0A0,  1, 0, 32'h4000);
        cyc(1, 32'h4008, 32'hB1B1B1B1,  1, 0, 32'h4004);
        cyc(1, 32'h400C, 32'hC2C2C2C2,  1, 0, 32'h4008);
    endtask

    logic [31:0] addr_r, data_r;
    int          sel;

    initial begin
        mmr_we = 0; mmr_location = 0; loadnoc_data = 0; noc_ready = 0;
        mmr_rd_addr = 0; reset = 1;
        for (int i = 0; i < 4; i++) m_pkt[i] = 0;
        m_err = 0; m_sticky = 0; m_done = 0; accepts = 0;
        repeat (2) @(posedge clk);

        // reset state readback
        for (int a = 0; a <= 4; a++) cyc(0, 0, 0, 0, 0, 32'h4000 + 32'(4 * a));

        // basic packet, ready held high
        load_pkt();
        cyc(1, 32'h4010, 32'h1, 1, 0, 32'h400C);
        idle(6, 1);
        check("status_after_done", mmr_rd_data, 32'h2);

        // stall 3 cycles on flit 2
        cyc(1, 32'h4010, 32'h1, 1, 0, 32'h4010);
        idle(2, 1);
        idle(3, 0);
        idle(5, 1);

        // write during SEND sets err, PKT[1] unchanged; clear afterwards
        cyc(1, 32'h4010, 32'h1, 1, 0, 32'h4004);
        cyc(1, 32'h4004, 32'hDEAD, 1, 0, 32'h4004);
        idle(5, 1);
        cyc(0, 0, 0, 1, 0, 32'h4004);
        check("pkt1_frozen", mmr_rd_data, 32'hA0A0A0A0);
        cyc(1, 32'h4010, 32'h2, 1, 0, 32'h4010);
        idle(2, 1);

        // start on final acceptance -> dropped; start in done cycle -> accepted
        cyc(1, 32'h4010, 32'h1, 1, 0, 32'h4010);
        idle(3, 1);
        cyc(1, 32'h4010, 32'h1, 1, 0, 32'h4010);
        cyc(1, 32'h4010, 32'h1, 1, 0, 32'h4010);
        idle(6, 1);
        cyc(1, 32'h4010, 32'h2, 1, 0, 32'h4010);

        // reset while flit 1 outstanding
        cyc(1, 32'h4010, 32'h1, 1, 0, 32'h4010);
        cyc(0, 0, 0, 1, 0, 32'h4010);
        cyc(0, 0, 0, 0, 1, 32'h4010);
        idle(3, 1);
        cyc(0, 0, 0, 1, 0, 32'h4000);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      addr_r = 32'h4000 + $urandom_range(0, 15);
            else if (sel < 8) addr_r = 32'h4010 + $urandom_range(0, 3);
            else if (sel < 9) addr_r = 32'h4014 + $urandom_range(0, 8);
            else              addr_r = $urandom;
            data_r = (addr_r >= 32'h4010 && addr_r <= 32'h4013 && $urandom_range(0, 3) != 0)
                     ? 32'($urandom_range(0, 3)) : $urandom;
            sel = int'($urandom_range(0, 9));
            cyc($urandom_range(0, 9) < 3, addr_r, data_r, $urandom_range(0, 9) < 7,
                $urandom_range(0, 299) == 0,
                (sel < 4) ? 32'h4000 + $urandom_range(0, 15) :
                (sel < 8) ? 32'h4010 + $urandom_range(0, 3) : $urandom);
        end
        idle(3, 1);
        if (accepts < 100) check("enough_accepts", 32'(accepts), 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
